mor1kx_ctrl_spr_access_cappuccino: RTL and testbench

Control-stage responder for mfspr/mtspr instructions held in the execute-to-ctrl pipeline register. It turns a pending ctrl-stage SPR op into one transaction on the SPR bus. It returns a single-cycle mfspr/mtspr acknowledge that releases the ctrl-stage stall, plus read data for writeback. A timeout guarantees forward progress when an SPR slave never answers.

---
 rtl/mor1kx_ctrl_spr_access_cappuccino_pkg.sv | 13 +
 rtl/mor1kx_spr_timeout_counter.sv | 29 ++
 rtl/mor1kx_ctrl_spr_access_cappuccino.sv | 149 ++++++++++++++
 tb/tb_mor1kx_ctrl_spr_access_cappuccino.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mor1kx_ctrl_spr_access_cappuccino_pkg.sv
// Shared definitions for ctrl-stage SPR bus responders: FSM encoding and
// the default bus-wait limit.
package mor1kx_ctrl_spr_access_cappuccino_pkg;

    typedef enum logic [1:0] {
        SPR_IDLE   = 2'd0,
        SPR_ACCESS = 2'd1,
        SPR_DONE   = 2'd2
    } spr_state_t;

    localparam int SPR_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/mor1kx_spr_timeout_counter.sv
// Bus-wait counter: cleared at the start of an access, advanced while the
// slave is silent, flags expiry once it has counted TIMEOUT-1 waits.
module mor1kx_spr_timeout_counter
    import mor1kx_ctrl_spr_access_cappuccino_pkg::*;
#(
    parameter int TIMEOUT = SPR_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expire = (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mor1kx_ctrl_spr_access_cappuccino.sv
// Ctrl-stage mfspr/mtspr responder: issues one SPR bus transaction per
// pending op and returns a single-cycle completion ack plus read data.
module mor1kx_ctrl_spr_access_cappuccino
    import mor1kx_ctrl_spr_access_cappuccino_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int SPR_ADDR_WIDTH       = 16,
    parameter int SPR_TIMEOUT          = SPR_TIMEOUT_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ctrl_op_mfspr_i,
    input  logic                            ctrl_op_mtspr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_rfb_i,
    input  logic                            padv_ctrl_i,
    input  logic                            pipeline_flush_i,
    output logic [SPR_ADDR_WIDTH-1:0]       spr_bus_addr_o,
    output logic                            spr_bus_we_o,
    output logic                            spr_bus_stb_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i,
    input  logic                            spr_bus_ack_i,
    output logic                            ctrl_mfspr_ack_o,
    output logic                            ctrl_mtspr_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] mfspr_dat_o,
    output logic                            spr_timeout_o
);

    spr_state_t                      state_reg, state_next;
    logic                            stb_reg, stb_next;
    logic                            we_reg, we_next;
    logic [SPR_ADDR_WIDTH-1:0]       addr_reg, addr_next;
    logic [OPTION_OPERAND_WIDTH-1:0] dat_reg, dat_next;
    logic                            mfspr_ack_reg, mfspr_ack_next;
    logic                            mtspr_ack_reg, mtspr_ack_next;
    logic [OPTION_OPERAND_WIDTH-1:0] mfspr_dat_reg, mfspr_dat_next;
    logic                            timeout_reg, timeout_next;

    logic cnt_clear;
    logic cnt_enable;
    logic cnt_expire;
    logic trigger;

    assign trigger = (ctrl_op_mfspr_i | ctrl_op_mtspr_i) & ~pipeline_flush_i;

    // Only the low address bits select an SPR; the rest of the ALU result is ignored.
    generate
        if (OPTION_OPERAND_WIDTH > SPR_ADDR_WIDTH) begin : g_unused_addr
            logic unused_addr_bits;
            assign unused_addr_bits = ^ctrl_alu_result_i[OPTION_OPERAND_WIDTH-1:SPR_ADDR_WIDTH];
        end
    endgenerate

    mor1kx_spr_timeout_counter #(
        .TIMEOUT(SPR_TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .enable(cnt_enable),
        .expire(cnt_expire)
    );

    always_comb begin
        state_next     = state_reg;
        stb_next       = stb_reg;
        we_next        = we_reg;
        addr_next      = addr_reg;
        dat_next       = dat_reg;
        mfspr_ack_next = 1'b0;
        mtspr_ack_next = 1'b0;
        timeout_next   = 1'b0;
        mfspr_dat_next = mfspr_dat_reg;
        cnt_clear      = 1'b0;
        cnt_enable     = 1'b0;

        unique case (state_reg)
            SPR_IDLE: begin
                if (trigger) begin
                    stb_next   = 1'b1;
                    we_next    = ctrl_op_mtspr_i;
                    addr_next  = ctrl_alu_result_i[SPR_ADDR_WIDTH-1:0];
                    dat_next   = ctrl_rfb_i;
                    cnt_clear  = 1'b1;
                    state_next = SPR_ACCESS;
                end
            end
            SPR_ACCESS: begin
                if (pipeline_flush_i) begin
                    stb_next   = 1'b0;
                    state_next = SPR_IDLE;
                end else if (spr_bus_ack_i || cnt_expire) begin
                    // A real ack takes priority over an expiry landing on the same cycle.
                    stb_next       = 1'b0;
                    mtspr_ack_next = we_reg;
                    mfspr_ack_next = ~we_reg;
                    timeout_next   = ~spr_bus_ack_i;
                    if (!we_reg) begin
                        mfspr_dat_next = spr_bus_ack_i ? spr_bus_dat_i : '0;
                    end
                    state_next = SPR_DONE;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            SPR_DONE: begin
                if (padv_ctrl_i || pipeline_flush_i) begin
                    state_next = SPR_IDLE;
                end
            end
            default: state_next = SPR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= SPR_IDLE;
            stb_reg       <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            dat_reg       <= '0;
            mfspr_ack_reg <= 1'b0;
            mtspr_ack_reg <= 1'b0;
            mfspr_dat_reg <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            stb_reg       <= stb_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            dat_reg       <= dat_next;
            mfspr_ack_reg <= mfspr_ack_next;
            mtspr_ack_reg <= mtspr_ack_next;
            mfspr_dat_reg <= mfspr_dat_next;
            timeout_reg   <= timeout_next;
        end
    end

    assign spr_bus_addr_o   = addr_reg;
    assign spr_bus_we_o     = we_reg;
    assign spr_bus_stb_o    = stb_reg;
    assign spr_bus_dat_o    = dat_reg;
    assign ctrl_mfspr_ack_o = mfspr_ack_reg;
    assign ctrl_mtspr_ack_o = mtspr_ack_reg;
    assign mfspr_dat_o      = mfspr_dat_reg;
    assign spr_timeout_o    = timeout_reg;

endmodule

// File: tb/tb_mor1kx_ctrl_spr_access_cappuccino.sv
// Directed bench for the ctrl-stage SPR responder with a transaction-level
// reference model compared every cycle, plus hand-computed literal checks.
module tb_mor1kx_ctrl_spr_access_cappuccino;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_op_mfspr_i, ctrl_op_mtspr_i;
    logic [31:0] ctrl_alu_result_i, ctrl_rfb_i;
    logic        padv_ctrl_i, pipeline_flush_i;
    logic [15:0] spr_bus_addr_o;
    logic        spr_bus_we_o, spr_bus_stb_o;
    logic [31:0] spr_bus_dat_o, spr_bus_dat_i;
    logic        spr_bus_ack_i;
    logic        ctrl_mfspr_ack_o, ctrl_mtspr_ack_o;
    logic [31:0] mfspr_dat_o;
    logic        spr_timeout_o;

    int checks = 0;
    int failures = 0;
    int ack_total = 0;
    bit cmp_en = 1'b0;
    bit prev_ack = 1'b0;

    always #5 clk = ~clk;

    mor1kx_ctrl_spr_access_cappuccino #(
        .OPTION_OPERAND_WIDTH(32),
        .SPR_ADDR_WIDTH      (16),
        .SPR_TIMEOUT         (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ctrl_op_mfspr_i  (ctrl_op_mfspr_i),
        .ctrl_op_mtspr_i  (ctrl_op_mtspr_i),
        .ctrl_alu_result_i(ctrl_alu_result_i),
        .ctrl_rfb_i       (ctrl_rfb_i),
        .padv_ctrl_i      (padv_ctrl_i),
        .pipeline_flush_i (pipeline_flush_i),
        .spr_bus_addr_o   (spr_bus_addr_o),
        .spr_bus_we_o     (spr_bus_we_o),
        .spr_bus_stb_o    (spr_bus_stb_o),
        .spr_bus_dat_o    (spr_bus_dat_o),
        .spr_bus_dat_i    (spr_bus_dat_i),
        .spr_bus_ack_i    (spr_bus_ack_i),
        .ctrl_mfspr_ack_o (ctrl_mfspr_ack_o),
        .ctrl_mtspr_ack_o (ctrl_mtspr_ack_o),
        .mfspr_dat_o      (mfspr_dat_o),
        .spr_timeout_o    (spr_timeout_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: a bus transaction is "open" from issue until answered,
    // expired or flushed; after completion the op is "held" until advance.
    logic        m_stb, m_we, m_mfack, m_mtack, m_tmo;
    logic [15:0] m_addr;
    logic [31:0] m_dat, m_mdat;
    bit          m_open, m_hold;
    int          m_waits;

    always @(posedge clk) begin
        if (rst) begin
            {m_stb, m_we, m_mfack, m_mtack, m_tmo} <= '0;
            m_addr <= '0; m_dat <= '0; m_mdat <= '0;
            m_open <= 0; m_hold <= 0; m_waits <= 0;
        end else begin
            m_mfack <= 0; m_mtack <= 0; m_tmo <= 0;
            if (m_open) begin
                if (pipeline_flush_i) begin
                    m_open <= 0; m_stb <= 0;
                end else if (spr_bus_ack_i || m_waits == TMO - 1) begin
                    m_open <= 0; m_stb <= 0; m_hold <= 1;
                    m_tmo <= !spr_bus_ack_i;
                    if (m_we) m_mtack <= 1;
                    else begin
                        m_mfack <= 1;
                        m_mdat  <= spr_bus_ack_i ? spr_bus_dat_i : 32'h0;
                    end
                end else begin
                    m_waits <= m_waits + 1;
                end
            end else if (m_hold) begin
                if (padv_ctrl_i || pipeline_flush_i) m_hold <= 0;
            end else if ((ctrl_op_mfspr_i || ctrl_op_mtspr_i) && !pipeline_flush_i) begin
                m_open <= 1; m_stb <= 1; m_waits <= 0;
                m_we   <= ctrl_op_mtspr_i;
                m_addr <= ctrl_alu_result_i[15:0];
                m_dat  <= ctrl_rfb_i;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_stb", {31'b0, spr_bus_stb_o}, {31'b0, m_stb});
            check("cyc_mfack", {31'b0, ctrl_mfspr_ack_o}, {31'b0, m_mfack});
            check("cyc_mtack", {31'b0, ctrl_mtspr_ack_o}, {31'b0, m_mtack});
            check("cyc_timeout", {31'b0, spr_timeout_o}, {31'b0, m_tmo});
            check("cyc_mfspr_dat", mfspr_dat_o, m_mdat);
            check("cyc_we", {31'b0, spr_bus_we_o}, {31'b0, m_we});
            check("cyc_addr", {16'b0, spr_bus_addr_o}, {16'b0, m_addr});
            check("cyc_bus_dat", spr_bus_dat_o, m_dat);
            if (ctrl_mfspr_ack_o || ctrl_mtspr_ack_o) begin
                ack_total++;
                check("ack_not_back_to_back", {31'b0, prev_ack}, 32'h0);
            end
            prev_ack = ctrl_mfspr_ack_o | ctrl_mtspr_ack_o;
        end
    end

    // Caller is at a negedge; ops are presented immediately.
    task automatic run_op(input bit mt, input logic [15:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int ack_at,
                          output int stb_n, output int lat, output bit saw_mf,
                          output bit saw_mt, output bit saw_tmo,
                          output logic [15:0] f_addr, output bit f_we, output logic [31:0] f_dat);
        bit got;
        got = 0;
        stb_n = 0; lat = 0; saw_mf = 0; saw_mt = 0; saw_tmo = 0;
        f_addr = '0; f_we = 0; f_dat = '0;
        ctrl_op_mfspr_i   = !mt;
        ctrl_op_mtspr_i   = mt;
        ctrl_alu_result_i = {16'hABCD, a};
        ctrl_rfb_i        = wd;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            spr_bus_ack_i = 1'b0;
            if (ctrl_mfspr_ack_o || ctrl_mtspr_ack_o) begin
                got = 1; lat = c;
                saw_mf = ctrl_mfspr_ack_o; saw_mt = ctrl_mtspr_ack_o; saw_tmo = spr_timeout_o;
            end else if (spr_bus_stb_o) begin
                stb_n++;
                if (stb_n == 1) begin
                    f_addr = spr_bus_addr_o; f_we = spr_bus_we_o; f_dat = spr_bus_dat_o;
                end
                if (stb_n == ack_at) begin
                    spr_bus_ack_i = 1'b1;
                    spr_bus_dat_i = rd;
                end
            end
        end
        check("ack_within_budget", {31'b0, got}, 32'h1);
        $display("txn mt=%0d addr=%h stb_cycles=%0d latency=%0d timeout=%0d mfspr_dat=%h",
                 mt, a, stb_n, lat, saw_tmo, mfspr_dat_o);
    endtask

    task automatic finish_op(input string tag);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({tag, "_no_restb"}, {31'b0, spr_bus_stb_o}, 32'h0);
        end
        padv_ctrl_i = 1'b1;
        @(negedge clk);
        padv_ctrl_i = 1'b0;
        ctrl_op_mfspr_i = 1'b0;
        ctrl_op_mtspr_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int sn, lt, acks_before;
        bit smf, smt, stm, fwe;
        logic [15:0] fa;
        logic [31:0] fd;

        rst = 1; ctrl_op_mfspr_i = 0; ctrl_op_mtspr_i = 0;
        ctrl_alu_result_i = 0; ctrl_rfb_i = 0; padv_ctrl_i = 0;
        pipeline_flush_i = 0; spr_bus_dat_i = 0; spr_bus_ack_i = 0;
        @(negedge clk);
        cmp_en = 1;
        @(negedge clk);
        check("reset_stb", {31'b0, spr_bus_stb_o}, 32'h0);
        check("reset_acks", {30'b0, ctrl_mfspr_ack_o, ctrl_mtspr_ack_o}, 32'h0);
        check("reset_mfspr_dat", mfspr_dat_o, 32'h0);
        check("reset_addr", {16'b0, spr_bus_addr_o}, 32'h0);
        rst = 0;
        @(negedge clk);

        // mfspr, slave answers on the third strobe cycle
        run_op(0, 16'h0011, 32'h0, 32'hDEADBEEF, 3, sn, lt, smf, smt, stm, fa, fwe, fd);
        check("t1_stb_cycles", sn, 3);
        check("t1_latency", lt, 4);
        check("t1_addr", {16'b0, fa}, 32'h0011);
        check("t1_we", {31'b0, fwe}, 32'h0);
        check("t1_mfack", {30'b0, smf, smt}, 32'h2);
        check("t1_mfspr_dat", mfspr_dat_o, 32'hDEADBEEF);
        finish_op("t1");

        // mtspr with immediate ack
        run_op(1, 16'h4802, 32'h12345678, 32'hFFFF0000, 1, sn, lt, smf, smt, stm, fa, fwe, fd);
        check("t2_stb_cycles", sn, 1);
        check("t2_latency", lt, 2);
        check("t2_we", {31'b0, fwe}, 32'h1);
        check("t2_bus_dat", fd, 32'h12345678);
        check("t2_addr", {16'b0, fa}, 32'h4802);
        check("t2_mtack", {30'b0, smf, smt}, 32'h1);
        check("t2_mfspr_dat_kept", mfspr_dat_o, 32'hDEADBEEF);
        finish_op("t2");

        // mfspr to a silent slave
        run_op(0, 16'h0123, 32'h0, 32'h0, 0, sn, lt, smf, smt, stm, fa, fwe, fd);
        check("t3_stb_cycles", sn, TMO);
        check("t3_timeout_with_ack", {30'b0, smf, stm}, 32'h3);
        check("t3_mfspr_dat", mfspr_dat_o, 32'h0);
        finish_op("t3");

        // flush in the second access cycle, with a bus ack in the same cycle
        ctrl_op_mfspr_i = 1; ctrl_alu_result_i = 32'h0000_0020;
        @(negedge clk);
        @(negedge clk);
        check("t4_stb_before_flush", {31'b0, spr_bus_stb_o}, 32'h1);
        pipeline_flush_i = 1; spr_bus_ack_i = 1; spr_bus_dat_i = 32'h55555555;
        @(negedge clk);
        pipeline_flush_i = 0; spr_bus_ack_i = 0; ctrl_op_mfspr_i = 0;
        check("t4_stb_dropped", {31'b0, spr_bus_stb_o}, 32'h0);
        check("t4_no_ack", {30'b0, ctrl_mfspr_ack_o, ctrl_mtspr_ack_o}, 32'h0);
        check("t4_mfspr_dat_kept", mfspr_dat_o, 32'h0);
        @(negedge clk);
        run_op(0, 16'h0040, 32'h0, 32'h0BADF00D, 2, sn, lt, smf, smt, stm, fa, fwe, fd);
        check("t4_next_stb_cycles", sn, 2);
        check("t4_next_mfspr_dat", mfspr_dat_o, 32'h0BADF00D);
        finish_op("t4");

        // back-to-back mfspr: advance with the next op already present
        acks_before = ack_total;
        run_op(0, 16'h0001, 32'h0, 32'hCAFE0001, 1, sn, lt, smf, smt, stm, fa, fwe, fd);
        check("t5a_mfspr_dat", mfspr_dat_o, 32'hCAFE0001);
        padv_ctrl_i = 1;
        @(negedge clk);
        padv_ctrl_i = 0;
        check("t5_idle_gap", {31'b0, spr_bus_stb_o}, 32'h0);
        run_op(0, 16'h0002, 32'h0, 32'hCAFE0002, 2, sn, lt, smf, smt, stm, fa, fwe, fd);
        check("t5b_stb_cycles", sn, 2);
        check("t5b_addr", {16'b0, fa}, 32'h0002);
        check("t5b_mfspr_dat", mfspr_dat_o, 32'hCAFE0002);
        finish_op("t5");
        check("t5_two_acks", ack_total - acks_before, 2);

        // reset in the middle of an access
        ctrl_op_mfspr_i = 1; ctrl_alu_result_i = 32'h0000_0777;
        @(negedge clk);
        @(negedge clk);
        check("t6_stb_before_rst", {31'b0, spr_bus_stb_o}, 32'h1);
        rst = 1; spr_bus_ack_i = 1; spr_bus_dat_i = 32'h77777777;
        @(negedge clk);
        rst = 0; spr_bus_ack_i = 0; ctrl_op_mfspr_i = 0;
        check("t6_stb", {31'b0, spr_bus_stb_o}, 32'h0);
        check("t6_acks", {29'b0, ctrl_mfspr_ack_o, ctrl_mtspr_ack_o, spr_timeout_o}, 32'h0);
        check("t6_mfspr_dat", mfspr_dat_o, 32'h0);
        check("t6_addr", {16'b0, spr_bus_addr_o}, 32'h0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
